// File: rtl/mem_bridge_pkg.sv
// mem_bridge_pkg -- shared types and widths for the 32-bit to 16-bit memory bridge.
//   state_e    : bridge FSM state encoding
//   HW_WIDTH   : memory halfword width (16)
//   WORD_WIDTH : CPU word width (32)
package mem_bridge_pkg;

    localparam int HW_WIDTH   = 16;
    localparam int WORD_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD0  = 3'd1,
        ST_RD1  = 3'd2,
        ST_RD2  = 3'd3,
        ST_WR0  = 3'd4,
        ST_WR1  = 3'd5,
        ST_RSP  = 3'd6
    } state_e;

endpackage

// File: rtl/mem_bridge.sv
// mem_bridge -- splits each CPU 32-bit word access into two big-endian 16-bit
// accesses on a synchronous-read halfword memory.
//
// Optional feature macro: MEM_BRIDGE_ALIGN_CHECK_EN
//   defined   : requests with req_addr[1:0] != 0 complete immediately with
//               rsp_err=1, rsp_rdata=0 and no memory access
//   undefined : req_addr[1:0] ignored, rsp_err is always 0
//
// Ports
//   clk, reset                   clock, asynchronous active-high reset
//   req_valid/req_ready          CPU request handshake
//   req_we, req_addr, req_wdata  request direction, byte address, write data
//   rsp_valid/rsp_ready          CPU response handshake
//   rsp_rdata, rsp_err           read data (0 after a write), misalign flag
//   mem_addr, mem_en, mem_rd_en, mem_wr_en, mem_dout   memory command side
//   mem_din                      memory read data, one cycle after the strobe
//
// state | meaning
// IDLE  | ready for a request
// RD0   | read strobe on high halfword (base)
// RD1   | read strobe on low halfword (base+1), high data returning
// RD2   | no strobe, low halfword data returning
// WR0   | write high halfword to base
// WR1   | write low halfword to base+1
// RSP   | response held until rsp_ready
module mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int MEM_DEPTH  = 4096,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH:0]   req_addr,
    input  logic [WORD_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WORD_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_en,
    output logic                  mem_rd_en,
    output logic                  mem_wr_en,
    output logic [HW_WIDTH-1:0]   mem_dout,
    input  logic [HW_WIDTH-1:0]   mem_din
);

    state_e                  state_q, state_d;
    // Word index: the halfword base is this with a 0 appended, so base+1 is
    // formed by appending a 1 and can never carry out of the address range.
    logic [ADDR_WIDTH-2:0]   word_q, word_d;
    logic [WORD_WIDTH-1:0]   wdata_q, wdata_d;
    logic [WORD_WIDTH-1:0]   rdata_q, rdata_d;
`ifdef MEM_BRIDGE_ALIGN_CHECK_EN
    logic                    err_q, err_d;
`else
    logic                    unused_addr_lsbs;
    assign unused_addr_lsbs = ^req_addr[1:0];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef MEM_BRIDGE_ALIGN_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef MEM_BRIDGE_ALIGN_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
`ifdef MEM_BRIDGE_ALIGN_CHECK_EN
        err_d     = err_q;
`endif
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        mem_addr  = '0;
        mem_en    = 1'b0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        mem_dout  = '0;

        unique case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    word_d  = req_addr[ADDR_WIDTH:2];
                    wdata_d = req_we ? req_wdata : '0;
                    // Cleared on every accept so a write responds with 0.
                    rdata_d = '0;
`ifdef MEM_BRIDGE_ALIGN_CHECK_EN
                    err_d   = 1'b0;
                    if (req_addr[1:0] != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = ST_RSP;
                    end else begin
                        state_d = req_we ? ST_WR0 : ST_RD0;
                    end
`else
                    state_d = req_we ? ST_WR0 : ST_RD0;
`endif
                end
            end
            ST_RD0: begin
                mem_en    = 1'b1;
                mem_rd_en = 1'b1;
                mem_addr  = {word_q, 1'b0};
                state_d   = ST_RD1;
            end
            ST_RD1: begin
                mem_en    = 1'b1;
                mem_rd_en = 1'b1;
                mem_addr  = {word_q, 1'b1};
                rdata_d[WORD_WIDTH-1:HW_WIDTH] = mem_din;
                state_d   = ST_RD2;
            end
            ST_RD2: begin
                rdata_d[HW_WIDTH-1:0] = mem_din;
                state_d   = ST_RSP;
            end
            ST_WR0: begin
                mem_en    = 1'b1;
                mem_wr_en = 1'b1;
                mem_addr  = {word_q, 1'b0};
                mem_dout  = wdata_q[WORD_WIDTH-1:HW_WIDTH];
                state_d   = ST_WR1;
            end
            ST_WR1: begin
                mem_en    = 1'b1;
                mem_wr_en = 1'b1;
                mem_addr  = {word_q, 1'b1};
                mem_dout  = wdata_q[HW_WIDTH-1:0];
                state_d   = ST_RSP;
            end
            ST_RSP: begin
                rsp_valid = 1'b1;
                rsp_rdata = rdata_q;
`ifdef MEM_BRIDGE_ALIGN_CHECK_EN
                rsp_err   = err_q;
`endif
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_bridge.sv
module tb_mem_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [12:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [11:0] mem_addr;
    logic        mem_en, mem_rd_en, mem_wr_en;
    logic [15:0] mem_dout, mem_din;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [0:4095];
    logic [32:0] exp_q [$];
    logic        mem_en_seen;
    logic        run_mon = 1'b0;

    mem_bridge dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_addr  (mem_addr),
        .mem_en    (mem_en),
        .mem_rd_en (mem_rd_en),
        .mem_wr_en (mem_wr_en),
        .mem_dout  (mem_dout),
        .mem_din   (mem_din)
    );

    always #5 clk = ~clk;

    // Synchronous-read halfword memory
    always @(posedge clk) begin
        if (mem_en) begin
            mem_en_seen <= 1'b1;
            if (mem_wr_en) mem[mem_addr] <= mem_dout;
            else if (mem_rd_en) mem_din <= mem[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Scoreboard monitor: compare on each response handshake, plus strobe rules.
    always @(negedge clk) begin
        if (run_mon) begin
            logic [32:0] e;
            chk("rd_wr_exclusive", {31'd0, mem_rd_en & mem_wr_en}, 32'd0);
            if (!mem_en)
                chk("idle_mem_outputs", {mem_rd_en, mem_wr_en, 2'b0, mem_addr, mem_dout}, 32'd0);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, e[32:1]);
                    chk("rsp_err", {31'd0, rsp_err}, {31'd0, e[0]});
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [12:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                         input int hold);
        int n;
        logic [31:0] snap;
        rsp_ready = (hold == 0);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!req_ready) chk("accept_timeout", 32'd1, 32'd0);
        exp_q.push_back({exp_rd, exp_err});
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
        chk("latency", n, exp_lat);
        if (hold > 0) begin
            snap = rsp_rdata;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
                chk("hold_rdata", rsp_rdata, snap);
                chk("hold_ready_low", {30'd0, req_ready, mem_en}, 32'd0);
            end
            rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk("back_to_idle", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic back_to_back(input logic we, input logic [12:0] addr, input logic [31:0] wd,
                                input logic [31:0] exp_rd, input int period);
        int n;
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back({exp_rd, 1'b0});
            n = 0;
            do begin @(posedge clk); #1; n++; end while (!req_ready && n < 20);
            chk("b2b_period", n, period);
        end
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        mem[12'h010] = 16'h1234; mem[12'h011] = 16'h5678;
        mem[12'h100] = 16'hA5A5; mem[12'h101] = 16'h0F0F;
        mem_din = 16'h0000; mem_en_seen = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
        reset = 1'b1;
        #2;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_mem", {mem_en, mem_rd_en, mem_wr_en, 1'b0, mem_addr, mem_dout}, 32'd0);
        #10 reset = 1'b0;
        @(posedge clk); #1;
        run_mon = 1'b1;

        issue(1'b0, 13'h0020, 32'h0, 32'h12345678, 1'b0, 3, 0);
        issue(1'b1, 13'h1FFC, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0);
        chk("mem_hw_ffe", {16'd0, mem[12'hFFE]}, 32'h0000DEAD);
        chk("mem_hw_fff", {16'd0, mem[12'hFFF]}, 32'h0000BEEF);
        issue(1'b0, 13'h1FFC, 32'h0, 32'hDEADBEEF, 1'b0, 3, 0);
        issue(1'b0, 13'h0200, 32'h0, 32'hA5A50F0F, 1'b0, 3, 5);

        // Reset in the middle of a write: only the high halfword lands.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 13'h0200; req_wdata = 32'h11112222;
        @(posedge clk); #1;          // accepted -> WR0
        req_valid = 1'b0;
        @(posedge clk); #1;          // WR1
        chk("in_wr1", {31'd0, mem_wr_en}, 32'd1);
        reset = 1'b1;
        #1;
        chk("midrst_mem", {mem_en, mem_rd_en, mem_wr_en, 1'b0, mem_addr, mem_dout}, 32'd0);
        chk("midrst_ready", {31'd0, req_ready}, 32'd1);
        chk("midrst_rsp", {rsp_valid, rsp_err, rsp_rdata[29:0]}, 32'd0);
        #4 reset = 1'b0;
        @(posedge clk); #1;
        chk("midrst_hi_written", {16'd0, mem[12'h100]}, 32'h00001111);
        chk("midrst_lo_kept", {16'd0, mem[12'h101]}, 32'h00000F0F);
        issue(1'b0, 13'h0200, 32'h0, 32'h11110F0F, 1'b0, 3, 0);

        mem_en_seen = 1'b0;
`ifdef MEM_BRIDGE_ALIGN_CHECK_EN
        issue(1'b0, 13'h0022, 32'h0, 32'h0, 1'b1, 0, 0);
        chk("misalign_no_strobe", {31'd0, mem_en_seen}, 32'd0);
`else
        issue(1'b0, 13'h0022, 32'h0, 32'h12345678, 1'b0, 3, 0);
        chk("unaligned_strobed", {31'd0, mem_en_seen}, 32'd1);
`endif

        back_to_back(1'b0, 13'h0020, 32'h0, 32'h12345678, 5);
        back_to_back(1'b1, 13'h0200, 32'hCAFEF00D, 32'h0, 4);
        issue(1'b0, 13'h0200, 32'h0, 32'hCAFEF00D, 1'b0, 3, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        run_mon = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 Parameter MEM_DEPTH, default 4096, number of 16-bit halfwords in the attached memory.
REQ-002 Parameter ADDR_WIDTH, default $clog2(MEM_DEPTH) = 12, halfword address width.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 req_valid  input  1  CPU word-access request.
REQ-007 req_ready  output  1  bridge can accept a request.
REQ-008 req_we  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  ADDR_WIDTH+1  byte address of a 32-bit word.
REQ-010 req_wdata  input  32  write data.
REQ-011 rsp_valid  output  1  access complete; rsp_rdata and rsp_err valid.
REQ-012 rsp_ready  input  1  CPU consumes response.
REQ-013 rsp_rdata  output  32  read data; 0 after a write.
REQ-014 rsp_err  output  1  misaligned access flag.
REQ-015 mem_addr  output  ADDR_WIDTH  halfword address to memory.
REQ-016 mem_en / mem_rd_en / mem_wr_en  output  1 each  memory port strobes.
REQ-017 mem_dout  output  16  write data to memory.
REQ-018 mem_din  input  16  read data from memory; valid one cycle after a read strobe (synchronous read).

Function
REQ-019 The bridge SHALL split every 32-bit access into two 16-bit accesses, big-endian: halfword base = req_addr[ADDR_WIDTH:2]*2 carries bits 31:16, base+1 carries bits 15:0.
REQ-020 FSM states: IDLE, RD0, RD1, RD2, WR0, WR1, RSP.
REQ-021 req_ready SHALL be 1 only in IDLE; a request is accepted at an edge where req_valid && req_ready, capturing req_addr, req_we and req_wdata.
REQ-022 IDLE -> RD0 on an accepted read; IDLE -> WR0 on an accepted write.
REQ-023 RD0: mem_en=1, mem_rd_en=1, mem_addr=base; -> RD1.
REQ-024 RD1: mem_en=1, mem_rd_en=1, mem_addr=base+1; capture mem_din into rdata[31:16] at exit; -> RD2.
REQ-025 RD2: strobes low; capture mem_din into rdata[15:0] at exit; -> RSP.
REQ-026 WR0: mem_en=1, mem_wr_en=1, mem_addr=base, mem_dout=wdata[31:16]; -> WR1.
REQ-027 WR1: mem_en=1, mem_wr_en=1, mem_addr=base+1, mem_dout=wdata[15:0]; -> RSP.
REQ-028 RSP: rsp_valid=1 with stable rsp_rdata/rsp_err until rsp_ready is sampled high; then -> IDLE.
REQ-029 Latency: rsp_valid rises 3 edges after read acceptance and 2 edges after write acceptance.
REQ-030 req_valid during RSP with rsp_ready SHALL NOT be accepted that cycle; acceptance happens in the following IDLE cycle.
REQ-031 mem_rd_en and mem_wr_en SHALL never both be 1; in IDLE, RD2 and RSP all strobes, mem_addr and mem_dout are 0.
REQ-032 base+1 never wraps (base is even); top word byte 0x1FFC maps to halfwords 0xFFE/0xFFF.

Reset
REQ-033 On reset the FSM SHALL go to IDLE immediately, including mid-transaction; req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, all memory outputs 0; an interrupted write may leave only the high halfword written.

Configuration
REQ-034 With MEM_BRIDGE_ALIGN_CHECK_EN defined, a request with req_addr[1:0] != 0 SHALL go IDLE -> RSP with rsp_err=1, rsp_rdata=0 and no memory strobe.
REQ-035 Without MEM_BRIDGE_ALIGN_CHECK_EN, req_addr[1:0] SHALL be ignored and rsp_err tied to 0.

Structure
REQ-036 Package mem_bridge_pkg SHALL hold the FSM state enum, HW_WIDTH=16 and WORD_WIDTH=32.
REQ-037 No sub-module; a single FSM plus capture registers.

Verification
REQ-038 Memory preloaded with 0x1234 at hw 0x010 and 0x5678 at hw 0x011; read byte 0x020 -> rsp_valid 3 edges after accept, rsp_rdata=0x12345678, rsp_err=0.
REQ-039 Write 0xDEADBEEF to byte 0x1FFC -> hw 0xFFE=0xDEAD, hw 0xFFF=0xBEEF, rsp_valid 2 edges after accept; read-back returns 0xDEADBEEF.
REQ-040 rsp_ready held low 5 cycles in RSP -> rsp_valid and rsp_rdata stable, req_ready=0 throughout, no memory strobes.
REQ-041 Reset asserted during WR1 -> all outputs 0 and req_ready=1 without waiting for a clock edge; next read completes normally.
REQ-042 With MEM_BRIDGE_ALIGN_CHECK_EN, read byte 0x022 -> rsp_err=1, rsp_rdata=0, mem_en never high; without the macro, same request returns word at 0x020.
REQ-043 Back-to-back requests with rsp_ready=1 and req_valid held high -> one transaction per 4 cycles (read) / 3 cycles (write) plus one IDLE cycle each.
